jtag_tap_controller: RTL

- IEEE 1149.1 TAP state machine. Sits directly upstream of jtag_instruction_register and the data-register chains.
- Consumes TMS on every rising TCK and tracks the standard 16-state TAP graph.
- Produces the decoded capture/shift/update strobes that gate the IR and DR shift paths, including tap_control, the IR shift enable.
- Also provides a saturating Run-Test/Idle dwell counter for RUNBIST-style instructions.

---
 rtl/jtag_tap_controller.sv | 107 ++++++++++
 1 files changed

// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - IEEE 1149.1 TAP state machine with decoded strobes and idle dwell counter
module jtag_tap_controller #(
   parameter int IDLE_CNT_WIDTH = 8
) (
   input  logic                      tck,
   input  logic                      trst_n,
   input  logic                      tms,
   output logic [3:0]                state,
   output logic                      test_logic_reset,
   output logic                      run_test_idle,
   output logic                      capture_dr,
   output logic                      shift_dr,
   output logic                      update_dr,
   output logic                      capture_ir,
   output logic                      shift_ir,
   output logic                      update_ir,
   output logic                      tap_control,
   output logic                      ir_select,
   output logic                      tdo_enable,
   output logic [IDLE_CNT_WIDTH-1:0] idle_count
);

   typedef enum logic [3:0] {
      TLR    = 4'hF,
      RTI    = 4'hC,
      SEL_DR = 4'h7,
      CAP_DR = 4'h6,
      SH_DR  = 4'h2,
      EX1_DR = 4'h1,
      PS_DR  = 4'h3,
      EX2_DR = 4'h0,
      UPD_DR = 4'h5,
      SEL_IR = 4'h4,
      CAP_IR = 4'hE,
      SH_IR  = 4'hA,
      EX1_IR = 4'h9,
      PS_IR  = 4'hB,
      EX2_IR = 4'h8,
      UPD_IR = 4'hD
   } tap_state_e;

   tap_state_e                state_q, state_d;
   logic [IDLE_CNT_WIDTH-1:0] idle_count_q, idle_count_d;

   // Next-state graph; every 4-bit code is a real TAP state so no recovery arc exists.
   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:    state_d = tms ? TLR    : RTI;
         RTI:    state_d = tms ? SEL_DR : RTI;
         SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms ? UPD_DR : PS_DR;
         PS_DR:  state_d = tms ? EX2_DR : PS_DR;
         EX2_DR: state_d = tms ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms ? SEL_DR : RTI;
         SEL_IR: state_d = tms ? TLR    : CAP_IR;
         CAP_IR: state_d = tms ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms ? UPD_IR : PS_IR;
         PS_IR:  state_d = tms ? EX2_IR : PS_IR;
         EX2_IR: state_d = tms ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms ? SEL_DR : RTI;
      endcase
   end

   // Dwell counter: counts edges that land in RTI, saturating so long BIST waits never wrap.
   always_comb begin
      idle_count_d = '0;
      if (state_d == RTI) begin
         if (state_q != RTI) begin
            idle_count_d = IDLE_CNT_WIDTH'(1);
         end else if (idle_count_q != '1) begin
            idle_count_d = idle_count_q + IDLE_CNT_WIDTH'(1);
         end else begin
            idle_count_d = idle_count_q;
         end
      end
   end

   // State and counter registers; trst_n overrides tck and holds TLR while low.
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         state_q      <= TLR;
         idle_count_q <= '0;
      end else begin
         state_q      <= state_d;
         idle_count_q <= idle_count_d;
      end
   end

   assign state            = state_q;
   assign test_logic_reset = (state_q == TLR);
   assign run_test_idle    = (state_q == RTI);
   assign capture_dr       = (state_q == CAP_DR);
   assign shift_dr         = (state_q == SH_DR);
   assign update_dr        = (state_q == UPD_DR);
   assign capture_ir       = (state_q == CAP_IR);
   assign shift_ir         = (state_q == SH_IR);
   assign update_ir        = (state_q == UPD_IR);
   assign tap_control      = shift_ir;
   assign ir_select        = (state_q inside {SEL_IR, CAP_IR, SH_IR, EX1_IR, PS_IR, EX2_IR, UPD_IR});
   assign tdo_enable       = shift_dr | shift_ir;
   assign idle_count       = idle_count_q;

endmodule
